// File: rtl/vga_timing_pkg.sv
// Shared constants and bundle types for the 640x480@60 VGA timing slice.
package vga_timing_pkg;

  localparam int COORD_W      = 10;
  localparam int VGA_COLOR_W  = 4;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP
                              + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP
                              + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [VGA_COLOR_W-1:0] r;
    logic [VGA_COLOR_W-1:0] g;
    logic [VGA_COLOR_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } tim_t;

endpackage

// File: rtl/vga_lock_qualifier.sv
// Synchronizes pll_locked and requires LOCK_WAIT consecutive locked
// cycles before declaring the timing generator running.
module vga_lock_qualifier #(
  parameter int LOCK_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic running,
  output logic running_next
);

  localparam int CW = $clog2(LOCK_WAIT + 1);
  localparam logic [CW-1:0] LW = CW'(LOCK_WAIT);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    cnt_d = '0;
    if (s2_q) cnt_d = (cnt_q == LW) ? cnt_q : cnt_q + 1'b1;
    run_d = s2_q & (cnt_d == LW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      s1_q  <= pll_locked;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign running      = run_q;
  assign running_next = run_d;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 timing generator: lock qualification, pixel requests and
// sync/DE re-alignment with returned frame-buffer data.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter bit SYNC_POL    = 1'b0,
  parameter int PIX_LATENCY = 2,
  parameter int LOCK_WAIT   = 16,
  parameter int COLOR_W     = VGA_COLOR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  output logic                 running,
  output logic                 frame_start,
  output logic                 req_valid,
  output logic [COORD_W-1:0]   req_x,
  output logic [COORD_W-1:0]   req_y,
  input  logic [3*COLOR_W-1:0] pix_rgb,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_geom_chk
    $error("vga_timing_gen: totals exceed 10-bit counters");
  end
  if (PIX_LATENCY < 1 || PIX_LATENCY > 8) begin : g_lat_chk
    $error("vga_timing_gen: PIX_LATENCY out of range 1..8");
  end

  localparam logic [COORD_W-1:0] HA  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS0 = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS1 = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] HL  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] VA  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS0 = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS1 = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] VL  = COORD_W'(V_TOTAL - 1);

  logic run, run_nx, go;

  vga_lock_qualifier #(.LOCK_WAIT(LOCK_WAIT)) u_lock (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .running      (run),
    .running_next (run_nx)
  );

  // go is low on the edge running falls, so everything flushes together
  assign go = run & run_nx;

  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic rv_q, rv_d, fs_q, fs_d;
  logic hsr_q, hsr_d, vsr_q, vsr_d;
  tim_t [PIX_LATENCY-1:0] dl_q, dl_d;
  tim_t tail;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (go) begin
      h_d = (h_q == HL) ? '0 : h_q + 1'b1;
      v_d = v_q;
      if (h_q == HL) v_d = (v_q == VL) ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    rv_d  = go & (h_q < HA) & (v_q < VA);
    fs_d  = go & (h_q == '0) & (v_q == '0);
    hsr_d = go & (h_q >= HS0) & (h_q < HS1);
    vsr_d = go & (v_q >= VS0) & (v_q < VS1);
    x_d   = rv_d ? h_q : x_q;
    y_d   = rv_d ? v_q : y_q;
  end

  always_comb begin
    dl_d = '0;
    if (run_nx) begin
      dl_d[0] = {hsr_q, vsr_q, rv_q};
      for (int i = 1; i < PIX_LATENCY; i++) dl_d[i] = dl_q[i-1];
    end
    tail  = dl_q[PIX_LATENCY-1];
    de_d  = run_nx & tail.de;
    hs_d  = (run_nx & tail.hs) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (run_nx & tail.vs) ? SYNC_POL : ~SYNC_POL;
    rgb_d = de_d ? pix_rgb : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      rv_q  <= 1'b0;
      fs_q  <= 1'b0;
      hsr_q <= 1'b0;
      vsr_q <= 1'b0;
      dl_q  <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      rgb_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      x_q   <= x_d;
      y_q   <= y_d;
      rv_q  <= rv_d;
      fs_q  <= fs_d;
      hsr_q <= hsr_d;
      vsr_q <= vsr_d;
      dl_q  <= dl_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign running     = run;
  assign frame_start = fs_q;
  assign req_valid   = rv_q;
  assign req_x       = x_q;
  assign req_y       = y_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for lock/line checks, a shrunken
// geometry instance (PIX_LATENCY=5) for frame, lock-loss and restart.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pl0, pl1;
  int   errors = 0;
  int   checks = 0;
  int   sel = 0;

  logic running0, fs0, rv0, hs0, vs0, de0;
  logic [9:0] x0, y0;
  logic [11:0] pix0;
  logic [3:0] r0, g0, b0;
  logic running1, fs1, rv1, hs1, vs1, de1;
  logic [9:0] x1, y1;
  logic [11:0] pix1;
  logic [3:0] r1, g1, b1;

  vga_timing_gen u0 (
    .clk(clk), .rst(rst), .pll_locked(pl0), .running(running0),
    .frame_start(fs0), .req_valid(rv0), .req_x(x0), .req_y(y0),
    .pix_rgb(pix0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .vga_hs(hs0), .vga_vs(vs0), .vga_de(de0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_LATENCY(5)
  ) u1 (
    .clk(clk), .rst(rst), .pll_locked(pl1), .running(running1),
    .frame_start(fs1), .req_valid(rv1), .req_x(x1), .req_y(y1),
    .pix_rgb(pix1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1)
  );

  // frame-buffer stand-in: fixed-latency return of a coordinate tag
  logic [11:0] pq0 [2];
  logic [11:0] pq1 [5];
  always @(posedge clk) begin
    pq0[0] <= rv0 ? {x0[3:0], y0[3:0], 4'hA} : 12'hFFF;
    pq0[1] <= pq0[0];
    pq1[0] <= rv1 ? {x1[3:0], y1[3:0], 4'hA} : 12'hFFF;
    for (int i = 1; i < 5; i++) pq1[i] <= pq1[i-1];
  end
  assign pix0 = pq0[1];
  assign pix1 = pq1[4];

  logic o_run, o_fs, o_rv, o_hs, o_vs, o_de;
  logic [9:0] o_x, o_y;
  logic [11:0] o_rgb;
  assign o_run = (sel == 1) ? running1 : running0;
  assign o_fs  = (sel == 1) ? fs1 : fs0;
  assign o_rv  = (sel == 1) ? rv1 : rv0;
  assign o_x   = (sel == 1) ? x1 : x0;
  assign o_y   = (sel == 1) ? y1 : y0;
  assign o_hs  = (sel == 1) ? hs1 : hs0;
  assign o_vs  = (sel == 1) ? vs1 : vs0;
  assign o_de  = (sel == 1) ? de1 : de0;
  assign o_rgb = (sel == 1) ? {r1, g1, b1} : {r0, g0, b0};

  function automatic void model(input int s, input int m,
                                output logic rv, output logic fs,
                                output logic hy, output logic vy,
                                output int h, output int v);
    int ha, hfp, hsw, ht, va, vfp, vsw, vt;
    if (s == 0) begin
      ha = 640; hfp = 16; hsw = 96; ht = 800;
      va = 480; vfp = 10; vsw = 2;  vt = 525;
    end else begin
      ha = 16; hfp = 2; hsw = 4; ht = 25;
      va = 6;  vfp = 1; vsw = 2; vt = 10;
    end
    rv = 0; fs = 0; hy = 0; vy = 0; h = 0; v = 0;
    if (m >= 0) begin
      h  = m % ht;
      v  = (m / ht) % vt;
      rv = (h < ha) && (v < va);
      fs = (h == 0) && (v == 0);
      hy = (h >= ha + hfp) && (h < ha + hfp + hsw);
      vy = (v >= va + vfp) && (v < va + vfp + vsw);
    end
  endfunction

  task automatic wait_run(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (o_run !== 1'b1 && c < 100);
  endtask

  // n=0 is the first request-stage cycle after running rises
  task automatic check_run(input int ncyc, input string tag);
    string nm [9] = '{"running", "req_valid", "req_x", "req_y",
                      "frame_start", "vga_de", "vga_hs", "vga_vs",
                      "vga_rgb"};
    int    bad [9];
    string msg [9];
    logic  rv, fs, hy, vy, dd, df, dh, dv;
    int    h, v, dx, dy, lat;
    rgb_t  er;
    lat = (sel == 1) ? 5 : 2;
    for (int k = 0; k < 9; k++) begin
      bad[k] = 0;
      msg[k] = "";
    end
    for (int n = 0; n < ncyc; n++) begin
      model(sel, n, rv, fs, hy, vy, h, v);
      model(sel, n - lat - 1, dd, df, dh, dv, dx, dy);
      er = dd ? {4'(dx), 4'(dy), 4'hA} : 12'h000;
      if (o_run !== 1'b1) begin
        if (bad[0] == 0) msg[0] = $sformatf("n=%0d got %b want 1", n, o_run);
        bad[0]++;
      end
      if (o_rv !== rv) begin
        if (bad[1] == 0) msg[1] = $sformatf("n=%0d got %b want %b", n, o_rv, rv);
        bad[1]++;
      end
      if (rv && o_x !== 10'(h)) begin
        if (bad[2] == 0) msg[2] = $sformatf("n=%0d got %0d want %0d", n, o_x, h);
        bad[2]++;
      end
      if (rv && o_y !== 10'(v)) begin
        if (bad[3] == 0) msg[3] = $sformatf("n=%0d got %0d want %0d", n, o_y, v);
        bad[3]++;
      end
      if (o_fs !== fs) begin
        if (bad[4] == 0) msg[4] = $sformatf("n=%0d got %b want %b", n, o_fs, fs);
        bad[4]++;
      end
      if (o_de !== dd) begin
        if (bad[5] == 0) msg[5] = $sformatf("n=%0d got %b want %b", n, o_de, dd);
        bad[5]++;
      end
      if (o_hs !== ~dh) begin
        if (bad[6] == 0) msg[6] = $sformatf("n=%0d got %b want %b", n, o_hs, ~dh);
        bad[6]++;
      end
      if (o_vs !== ~dv) begin
        if (bad[7] == 0) msg[7] = $sformatf("n=%0d got %b want %b", n, o_vs, ~dv);
        bad[7]++;
      end
      if (o_rgb !== er) begin
        if (bad[8] == 0) msg[8] = $sformatf("n=%0d got %h want %h", n, o_rgb, er);
        bad[8]++;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (bad[k] != 0) begin
        errors++;
        $display("FAIL %s.%s: %0d bad cycles, first %s",
                 tag, nm[k], bad[k], msg[k]);
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    pl0 = 1'b0;
    pl1 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({o_run, o_fs, o_rv, o_de} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000", {o_run, o_fs, o_rv, o_de});
    end
    checks++;
    if ({o_x, o_y} !== 20'd0) begin
      errors++;
      $display("FAIL reset_xy: got %0d,%0d want 0,0", o_x, o_y);
    end
    checks++;
    if (o_rgb !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb: got %h want 000", o_rgb);
    end
    checks++;
    if ({o_hs, o_vs} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync: got %b want 11", {o_hs, o_vs});
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_qualify();
    int c;
    sel = 0;
    pl0 = 1'b1;
    wait_run(c);
    checks++;
    if (c != 18) begin
      errors++;
      $display("FAIL lock_latency: got %0d cycles want 18", c);
    end
    checks++;
    if (o_fs !== 1'b0) begin
      errors++;
      $display("FAIL lock_fs_early: got %b want 0", o_fs);
    end
    @(negedge clk);
  endtask

  task automatic test_line_timing();
    sel = 0;
    check_run(1700, "line");
  endtask

  task automatic test_glitch_lock();
    int c;
    sel = 0;
    pl0 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({o_run, o_de, o_rv} !== 3'b000) begin
      errors++;
      $display("FAIL unlock_drop: got %b want 000", {o_run, o_de, o_rv});
    end
    checks++;
    if ({o_hs, o_vs} !== 2'b11) begin
      errors++;
      $display("FAIL unlock_sync: got %b want 11", {o_hs, o_vs});
    end
    pl0 = 1'b1;
    repeat (10) @(negedge clk);
    pl0 = 1'b0;
    @(negedge clk);
    pl0 = 1'b1;
    wait_run(c);
    checks++;
    if (c != 18) begin
      errors++;
      $display("FAIL glitch_lock: got %0d cycles after glitch want 18", c);
    end
    @(negedge clk);
    check_run(900, "relock");
  endtask

  task automatic test_frame_timing();
    int c;
    sel = 1;
    pl1 = 1'b1;
    wait_run(c);
    checks++;
    if (c != 18) begin
      errors++;
      $display("FAIL lock1_latency: got %0d cycles want 18", c);
    end
    @(negedge clk);
    check_run(600, "frame");
    c = 0;
    while (o_fs !== 1'b1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != 150) begin
      errors++;
      $display("FAIL frame_phase: got %0d want 150", c);
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (o_fs !== 1'b1 && c < 1000);
    checks++;
    if (c != 250) begin
      errors++;
      $display("FAIL frame_period: got %0d want 250", c);
    end
  endtask

  task automatic test_lock_loss();
    int c;
    sel = 1;
    repeat (85) @(negedge clk);
    pl1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_run, o_rv, o_de} !== 3'b000) begin
      errors++;
      $display("FAIL loss_flush: got %b want 000", {o_run, o_rv, o_de});
    end
    checks++;
    if ({o_hs, o_vs, o_rgb} !== {2'b11, 12'h000}) begin
      errors++;
      $display("FAIL loss_out: got %b/%h want 11/000", {o_hs, o_vs}, o_rgb);
    end
    pl1 = 1'b1;
    wait_run(c);
    checks++;
    if (c != 18) begin
      errors++;
      $display("FAIL restart_latency: got %0d cycles want 18", c);
    end
    @(negedge clk);
    check_run(300, "restart");
  endtask

  initial begin
    test_reset();
    test_lock_qualify();
    test_line_timing();
    test_glitch_lock();
    test_frame_timing();
    test_lock_loss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Downstream consumer of the 50 MHz -> 25.175 MHz VGA pixel PLL; runs entirely in the pixel clock domain.
- Qualifies the PLL lock, generates 640x480@60 horizontal/vertical counters, and issues pixel requests to the frame-buffer read path.
- Re-aligns HSYNC/VSYNC/DE with the returned pixel data and drives the registered VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of vga_hs/vga_vs (0 = active-low)
- PIX_LATENCY, 2, cycles from req_valid to pix_rgb valid; range 1..8
- LOCK_WAIT, 16, consecutive synchronized-locked cycles required before running
- COLOR_W, 4, bits per colour channel

Ports:
- clk  in  1  pixel clock (PLL outclk_0)
- rst  in  1  synchronous reset, active-high
- pll_locked  in  1  PLL locked, asynchronous to clk
- running  out  1  timing active (lock qualified)
- frame_start  out  1  one-cycle pulse at request-stage h=0, v=0
- req_valid  out  1  pixel request in active area
- req_x  out  10  requested column 0..H_ACTIVE-1
- req_y  out  10  requested row 0..V_ACTIVE-1
- pix_rgb  in  3*COLOR_W  {R,G,B} returned exactly PIX_LATENCY cycles after req_valid
- vga_r/vga_g/vga_b  out  COLOR_W each  pixel colour, zero in blanking
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  active-video indicator

Behaviour:
- Reset: running=0, frame_start=0, req_valid=0, req_x=req_y=0, vga_r/g/b=0, vga_de=0, vga_hs=vga_vs=~SYNC_POL; counters, lock counter and delay lines cleared.
- H_TOTAL = 800 and V_TOTAL = 525 are derived from the parameters.
- Lock qualifier:
  - 2-flop synchronizer on pll_locked.
  - Saturating counter increments while the synchronized value is 1. running rises the cycle the count reaches LOCK_WAIT.
  - Synchronized value 0 clears the counter and drops running on the next edge, mid-frame included.
- Counters:
  - While running=0: h=0, v=0.
  - While running=1: h increments each cycle and wraps H_TOTAL-1 -> 0. v increments on h wrap and wraps V_TOTAL-1 -> 0.
  - The first running cycle presents h=0, v=0.
- Request stage (registered from the counters):
  - req_valid = running & h<H_ACTIVE & v<V_ACTIVE; req_x=h, req_y=v.
  - req_x and req_y hold their last value when req_valid=0.
  - frame_start = running & h==0 & v==0, aligned with the request stage.
- Timing windows, computed in the request stage:
  - hs_raw when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - de_raw = req_valid.
- Alignment:
  - hs_raw, vs_raw and de_raw pass through a PIX_LATENCY-deep shift register, then one output register.
  - vga_* therefore lag the request stage by PIX_LATENCY+1 cycles.
  - pix_rgb is sampled on the cycle the delayed de is present. vga_rgb = delayed_de ? pix_rgb : 0.
  - vga_hs = delayed_hs ? SYNC_POL : ~SYNC_POL; vga_vs likewise.
- Loss of running, from rst or lock loss:
  - Delay lines flush to inactive (de=0, hs/vs inactive) on the same edge.
  - No partial pixels are emitted.
  - Restart always begins at h=0, v=0 with a fresh frame_start.
- Widths: h and v are 10 bits. Static assertion that H_TOTAL and V_TOTAL are <= 1024.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 constants (porches, sync widths, totals)
  - COORD_W=10
  - rgb struct/typedef {r,g,b} of COLOR_W
- Sub-module vga_lock_qualifier contains the synchronizer and LOCK_WAIT counter; it outputs running.

Test Plan:
- Lock qualification: rst high 4 cycles, release, pll_locked=1 -> running rises 2+16 cycles later (±1 for synchronizer); frame_start pulses at the first request-stage cycle.
- Line timing, running: req_valid high 640 cycles with req_x 0..639, low 160; vga_hs asserted (0) for exactly 96 cycles starting 656+PIX_LATENCY+1 cycles after line start.
- Frame timing: count lines -> 525 per frame; vga_vs low for lines 490-491 (1600 cycles); frame_start period exactly 420000 cycles.
- Data alignment: pix_rgb model returns {req_x[3:0], req_y[3:0], 4'hA} after PIX_LATENCY=2 -> every vga_de=1 cycle shows the matching value; vga_rgb=0 whenever vga_de=0; repeat with PIX_LATENCY=5.
- Lock loss mid-line: drop pll_locked at h=300, v=100 -> within 3 cycles running=0, vga_de=0, hs/vs inactive; reassert -> restart at h=0, v=0 after LOCK_WAIT.
- Glitchy lock: pll_locked high 10 cycles, low 1, high -> running stays 0 until 16 consecutive synchronized-high cycles.
